// File: rtl/bus_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_initiator_pkg
// Description : Shared femto peripheral-bus definitions. Holds the bus data
//               and access-size widths, the access-size encodings, the
//               response status codes and the initiator FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_initiator_pkg;

  // Bus data path and access-size field
  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // Upstream response status codes
  localparam int BUS_ST_WIDTH = 2;

  localparam logic [BUS_ST_WIDTH-1:0] BUS_ST_OK      = 2'd0;
  localparam logic [BUS_ST_WIDTH-1:0] BUS_ST_FAULT   = 2'd1;
  localparam logic [BUS_ST_WIDTH-1:0] BUS_ST_TIMEOUT = 2'd2;

  // Width of the WAIT-state timeout counter (TIMEOUT is limited to 1..255)
  localparam int TMO_CNT_WIDTH = 8;

  // Initiator FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bus_init_state_e;

endpackage : bus_initiator_pkg
`default_nettype wire

// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : bus_initiator
// Description : Single-outstanding femto-bus initiator. Accepts one command
//               via valid/ready, issues a one-cycle bus request, waits for
//               resp / fault / timeout and returns one status+data beat.
// Ports       :
//   clk, rst                    - clock, synchronous active-high reset
//   cmd_valid/cmd_ready         - command handshake
//   cmd_addr/w_rb/acc/wdata     - command fields
//   rsp_valid/rsp_ready         - response handshake
//   rsp_rdata/rsp_status        - response payload
//   req/addr/w_rb/acc/wdata     - bus request (fields registered)
//   resp/fault/rdata            - bus responder inputs
// Revision    : 1.0 - initial release
// ============================================================================
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  // command side
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic                     cmd_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] cmd_acc,
  input  logic [BUS_WIDTH-1:0]     cmd_wdata,
  // response side
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BUS_WIDTH-1:0]     rsp_rdata,
  output logic [BUS_ST_WIDTH-1:0]  rsp_status,
  // femto bus
  output logic                     req,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     w_rb,
  output logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     resp,
  input  logic                     fault,
  input  logic [BUS_WIDTH-1:0]     rdata
);

  // Counter value on the last WAIT cycle before the transaction is aborted
  localparam logic [TMO_CNT_WIDTH-1:0] TMO_LAST = TMO_CNT_WIDTH'(TIMEOUT - 1);

  bus_init_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       w_rb_q, w_rb_d;
  logic [BUS_ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [BUS_WIDTH-1:0]       wdata_q, wdata_d;
  logic [TMO_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BUS_ST_WIDTH-1:0]    status_q, status_d;
  logic [BUS_WIDTH-1:0]       rdata_q, rdata_d;

  // Read data is only meaningful for reads; writes always report zero.
  logic [BUS_WIDTH-1:0]       w_rdata_cap;
  assign w_rdata_cap = w_rb_q ? '0 : rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      w_rb_q   <= 1'b0;
      acc_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      status_q <= BUS_ST_OK;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      w_rb_q   <= w_rb_d;
      acc_q    <= acc_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    w_rb_d   = w_rb_q;
    acc_d    = acc_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          w_rb_d  = cmd_w_rb;
          acc_d   = cmd_acc;
          wdata_d = cmd_wdata;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // fault is only meaningful alongside req and wins over resp
        if (fault) begin
          status_d = BUS_ST_FAULT;
          rdata_d  = '0;
          state_d  = ST_DONE;
        end else if (resp) begin
          status_d = BUS_ST_OK;
          rdata_d  = w_rdata_cap;
          state_d  = ST_DONE;
        end else begin
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (resp) begin
          status_d = BUS_ST_OK;
          rdata_d  = w_rdata_cap;
          state_d  = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          status_d = BUS_ST_TIMEOUT;
          rdata_d  = '0;
          state_d  = ST_DONE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded from the state register only; no path from cmd_valid.
  assign cmd_ready  = (state_q == ST_IDLE) & ~rst;
  assign req        = (state_q == ST_REQ);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_status = status_q;
  assign rsp_rdata  = rdata_q;
  assign addr       = addr_q;
  assign w_rb       = w_rb_q;
  assign acc        = acc_q;
  assign wdata      = wdata_q;

endmodule : bus_initiator
`default_nettype wire

// File: tb/tb_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_initiator
// Description : Directed self-checking bench for bus_initiator. Expected
//               responses are queued when a command is issued and popped
//               when the initiator presents rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_initiator;
  import bus_initiator_pkg::*;

  localparam int AW  = 32;
  localparam int TMO = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     cmd_valid = 1'b0;
  logic                     cmd_ready;
  logic [AW-1:0]            cmd_addr = '0;
  logic                     cmd_w_rb = 1'b0;
  logic [BUS_ACC_WIDTH-1:0] cmd_acc = '0;
  logic [BUS_WIDTH-1:0]     cmd_wdata = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic [BUS_WIDTH-1:0]     rsp_rdata;
  logic [BUS_ST_WIDTH-1:0]  rsp_status;
  logic                     req;
  logic [AW-1:0]            addr;
  logic                     w_rb;
  logic [BUS_ACC_WIDTH-1:0] acc;
  logic [BUS_WIDTH-1:0]     wdata;
  logic                     resp = 1'b0;
  logic                     fault = 1'b0;
  logic [BUS_WIDTH-1:0]     rdata = '0;

  bus_initiator #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_w_rb(cmd_w_rb), .cmd_acc(cmd_acc), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status),
    .req(req), .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
    .resp(resp), .fault(fault), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [BUS_ST_WIDTH-1:0] st;
    logic [BUS_WIDTH-1:0]    rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_cyc  = 0;
  int   acc_prev = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [BUS_ST_WIDTH-1:0] st, input logic [BUS_WIDTH-1:0] rd);
    exp_t e;
    e.st = st;
    e.rd = rd;
    sb.push_back(e);
  endtask

  // Issue one command; returns in cycle 1 (the req cycle).
  task automatic send(input logic w, input logic [AW-1:0] a,
                      input logic [BUS_ACC_WIDTH-1:0] ac, input logic [BUS_WIDTH-1:0] wd);
    cmd_w_rb  = w;
    cmd_addr  = a;
    cmd_acc   = ac;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    acc_prev = acc_cyc;
    acc_cyc  = cyc;
    tick();
    cmd_valid = 1'b0;
    chk("req_cycle1", 64'(req), 64'd1);
    chk("addr_latched", 64'(addr), 64'(a));
    chk("w_rb_latched", 64'(w_rb), 64'(w));
    chk("acc_latched", 64'(acc), 64'(ac));
    chk("wdata_latched", 64'(wdata), 64'(wd));
  endtask

  // Compare the presented response against the oldest expectation.
  task automatic pop_chk(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_status"}, 64'(rsp_status), 64'(e.st));
      chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rd));
    end
  endtask

  initial begin
    int n;

    // ---------------- reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_status", 64'(rsp_status), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_w_rb", 64'(w_rb), 64'd0);
    chk("rst_acc", 64'(acc), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // ---------------- write 1B, registered responder
    rsp_ready = 1'b1;
    push(BUS_ST_OK, 32'h0);
    send(1'b1, 32'h0, BUS_ACC_1B, 32'h01);
    tick();                                   // cycle 2
    chk("wr_req_one_cycle", 64'(req), 64'd0);
    chk("wr_no_early_valid", 64'(rsp_valid), 64'd0);
    resp = 1'b1;
    rdata = 32'hFFFF_FFFF;
    tick();                                   // cycle 3
    resp = 1'b0;
    pop_chk("wr1");
    tick();
    chk("wr_back_idle", 64'(rsp_valid), 64'd0);

    // ---------------- read 4B, resp five cycles after req
    push(BUS_ST_OK, 32'hDEAD_BEEF);
    send(1'b0, 32'h10, BUS_ACC_4B, 32'h0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("rd_wait_req", 64'(req), 64'd0);
      chk("rd_wait_addr", 64'(addr), 64'h10);
      chk("rd_wait_valid", 64'(rsp_valid), 64'd0);
    end
    tick();                                   // cycle 6
    chk("rd_wait_addr6", 64'(addr), 64'h10);
    resp = 1'b1;
    rdata = 32'hDEAD_BEEF;
    tick();                                   // cycle 7
    resp = 1'b0;
    rdata = 32'h0;
    pop_chk("rd_slow");
    tick();

    // ---------------- fault in the req cycle, stray resp afterwards
    push(BUS_ST_FAULT, 32'h0);
    send(1'b1, 32'h40, BUS_ACC_2B, 32'hABCD);
    fault = 1'b1;
    tick();                                   // cycle 2
    fault = 1'b0;
    rsp_ready = 1'b0;
    resp = 1'b1;
    rdata = 32'h5555_5555;
    pop_chk("fault");
    tick();                                   // cycle 3
    resp = 1'b0;
    chk("fault_hold_valid", 64'(rsp_valid), 64'd1);
    chk("fault_hold_status", 64'(rsp_status), 64'(BUS_ST_FAULT));
    chk("fault_hold_rdata", 64'(rsp_rdata), 64'd0);
    rsp_ready = 1'b1;
    tick();
    chk("fault_back_idle", 64'(rsp_valid), 64'd0);

    // ---------------- timeout, then a same-cycle responder
    push(BUS_ST_TIMEOUT, 32'h0);
    rdata = 32'h7777_7777;
    send(1'b0, 32'h20, BUS_ACC_4B, 32'h0);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("timeout_latency", 64'(n), 64'd18);
    pop_chk("timeout");
    tick();

    push(BUS_ST_OK, 32'h1234_5678);
    send(1'b0, 32'h24, BUS_ACC_4B, 32'h0);
    resp = 1'b1;
    rdata = 32'h1234_5678;
    tick();                                   // cycle 2
    resp = 1'b0;
    pop_chk("same_cycle");
    tick();

    // ---------------- rsp_ready withheld for 10 cycles
    rsp_ready = 1'b0;
    push(BUS_ST_OK, 32'h0);
    send(1'b1, 32'h4, BUS_ACC_4B, 32'hCAFE);
    tick();
    resp = 1'b1;
    rdata = 32'h9999_9999;
    tick();
    resp = 1'b0;
    pop_chk("hold_first");
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 32'h99;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_status", 64'(rsp_status), 64'(BUS_ST_OK));
      chk("hold_rdata", 64'(rsp_rdata), 64'd0);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_addr", 64'(addr), 64'h4);
      tick();
    end
    cmd_valid = 1'b0;
    chk("hold_no_accept", 64'(addr), 64'h4);
    rsp_ready = 1'b1;
    tick();

    // back-to-back pair, registered responder
    push(BUS_ST_OK, 32'h1111);
    send(1'b0, 32'h8, BUS_ACC_4B, 32'h0);
    tick();
    resp = 1'b1;
    rdata = 32'h1111;
    tick();
    resp = 1'b0;
    pop_chk("b2b_a");
    tick();
    push(BUS_ST_OK, 32'h2222);
    send(1'b0, 32'hC, BUS_ACC_4B, 32'h0);
    chk("b2b_spacing", 64'(acc_cyc - acc_prev), 64'd4);
    tick();
    resp = 1'b1;
    rdata = 32'h2222;
    tick();
    resp = 1'b0;
    pop_chk("b2b_b");
    tick();

    // ---------------- reset pulse during WAIT
    send(1'b0, 32'h30, BUS_ACC_4B, 32'h0);
    tick();                                   // in WAIT
    rst = 1'b1;
    tick();
    chk("midrst_req", 64'(req), 64'd0);
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("midrst_addr", 64'(addr), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 64'(cmd_ready), 64'd1);
    resp = 1'b1;                              // late resp, must be ignored
    tick();
    resp = 1'b0;
    chk("midrst_no_valid1", 64'(rsp_valid), 64'd0);
    chk("midrst_no_req", 64'(req), 64'd0);
    tick();
    chk("midrst_no_valid2", 64'(rsp_valid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // normal transaction after the abandoned one
    push(BUS_ST_OK, 32'hABCD_EF01);
    send(1'b0, 32'h34, BUS_ACC_4B, 32'h0);
    resp = 1'b1;
    rdata = 32'hABCD_EF01;
    tick();
    resp = 1'b0;
    pop_chk("after_rst");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bus_initiator
`default_nettype wire
